// File: rtl/forward_activate_pkg.sv
// Shared definitions for the forward activation stage: mode encoding,
// accumulator width helper and the leaky-ReLU shift amount.
package forward_activate_pkg;

  typedef enum logic {
    MODE_TEST  = 1'b0,
    MODE_TRAIN = 1'b1
  } mode_e;

  // A lane accumulates NP products of WF-bit operands plus bias.
  function automatic int acc_width(input int np, input int wf);
    return $clog2(np) + 1 + wf;
  endfunction

  localparam int LEAKY_SHIFT = 3;

endpackage

// File: rtl/forward_activate_if.sv
// Accumulator input bus plus the forked State / Mask output buses.
// slave = activation stage view, master = producer/consumer view.
interface forward_activate_if #(
  parameter int NC = 11,
  parameter int WA = 9,
  parameter int WF = 5
);
  logic             iMode;
  logic             iValid_AM_Accum;
  logic             oReady_AM_Accum;
  logic [NC*WA-1:0] iData_AM_Accum;
  logic             oValid_BM_State;
  logic             iReady_BM_State;
  logic [NC*WF-1:0] oData_BM_State;
  logic             oValid_BM_Mask;
  logic             iReady_BM_Mask;
  logic [NC-1:0]    oData_BM_Mask;

  modport slave (
    input  iMode, iValid_AM_Accum, iData_AM_Accum, iReady_BM_State, iReady_BM_Mask,
    output oReady_AM_Accum, oValid_BM_State, oData_BM_State, oValid_BM_Mask, oData_BM_Mask
  );

  modport master (
    output iMode, iValid_AM_Accum, iData_AM_Accum, iReady_BM_State, iReady_BM_Mask,
    input  oReady_AM_Accum, oValid_BM_State, oData_BM_State, oValid_BM_Mask, oData_BM_Mask
  );
endinterface

// File: rtl/forward_activate_lane.sv
// activate_lane: combinational saturate -> ReLU -> derivative mask for one
// accumulator lane. Leaky variant selected by FORWARD_ACTIVATE_LEAKY_EN.
module activate_lane
  import forward_activate_pkg::*;
#(
  parameter int WA = 9,
  parameter int WF = 5
) (
  input  logic signed [WA-1:0] i_acc,
  output logic        [WF-1:0] o_state,
  output logic                 o_mask
);
  localparam logic signed [WA-1:0] MAXV = WA'(2**(WF-1) - 1);
  localparam logic signed [WA-1:0] MINV = WA'(-(2**(WF-1)));
  localparam logic signed [WA-1:0] ZERO = '0;

  logic signed [WF-1:0] w_sat;
  logic signed [WF-1:0] w_neg;
  logic                 w_pos;

  // Clamp the wide accumulator into the signed WF-bit range.
  always_comb begin
    w_sat = i_acc[WF-1:0];
    if (i_acc > MAXV)      w_sat = MAXV[WF-1:0];
    else if (i_acc < MINV) w_sat = MINV[WF-1:0];
  end

  // s > 0 exactly when a > 0, so one compare serves both ReLU and mask.
  assign w_pos = (i_acc > ZERO);

`ifdef FORWARD_ACTIVATE_LEAKY_EN
  assign w_neg = w_sat >>> LEAKY_SHIFT;
`else
  assign w_neg = '0;
`endif

  assign o_state = w_pos ? w_sat : w_neg;
  assign o_mask  = w_pos;

endmodule

// File: rtl/forward_activate.sv
// forward_activate: NC-lane saturating ReLU stage between the forward MAC
// and the next layer. One head entry (plus a skid slot when BURST="yes")
// with independent State / Mask pending flags forming a two-way fork.
// Optional macro: FORWARD_ACTIVATE_LEAKY_EN (leaky ReLU in each lane).
module forward_activate
  import forward_activate_pkg::*;
#(
  parameter int    NP    = 7,
  parameter int    NC    = 11,
  parameter int    WF    = 5,
  parameter string BURST = "yes"
) (
  input logic               iCLK,
  input logic               iRST,
  forward_activate_if.slave bus
);
  localparam int WA   = acc_width(NP, WF);
  localparam bit SKID = (BURST == "yes");

  typedef struct packed {
    logic             train;
    logic [NC-1:0]    mask;
    logic [NC*WF-1:0] state;
  } entry_t;

  logic [NC*WF-1:0] w_state;
  logic [NC-1:0]    w_mask;
  entry_t           w_new;

  entry_t r_hd, r_sk;
  logic   r_pend_s, r_pend_m, r_sk_vld, r_rdy, r_live;

  logic w_hd_vld, w_s_hs, w_m_hs, w_s_left, w_m_left, w_hd_free;
  logic w_acc, w_ready, w_sk_nxt;

  for (genvar g = 0; g < NC; g++) begin : g_lane
    activate_lane #(.WA(WA), .WF(WF)) u_lane (
      .i_acc  (bus.iData_AM_Accum[g*WA +: WA]),
      .o_state(w_state[g*WF +: WF]),
      .o_mask (w_mask[g])
    );
  end

  assign w_new = '{train: (bus.iMode == MODE_TRAIN), mask: w_mask, state: w_state};

  // Head is occupied exactly while one of its flags is still pending.
  assign w_hd_vld  = r_pend_s | r_pend_m;
  assign w_s_hs    = r_pend_s & bus.iReady_BM_State;
  assign w_m_hs    = r_pend_m & bus.iReady_BM_Mask;
  assign w_s_left  = r_pend_s & ~w_s_hs;
  assign w_m_left  = r_pend_m & ~w_m_hs;
  // Head is empty after this edge: it was empty or both flags clear now.
  assign w_hd_free = ~w_s_left & ~w_m_left;

  // Skid mode: registered "skid empty". Single mode: "no entry held".
  assign w_ready = SKID ? r_rdy : (r_live & ~w_hd_vld);
  assign w_acc   = bus.iValid_AM_Accum & w_ready;

  // Skid occupancy after this edge, used to precompute the registered ready.
  assign w_sk_nxt = SKID & (w_hd_free ? (r_sk_vld & w_acc) : (r_sk_vld | w_acc));

  // Head/skid update: load, advance, retire and per-consumer flag clearing.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_hd     <= '0;
      r_sk     <= '0;
      r_pend_s <= 1'b0;
      r_pend_m <= 1'b0;
      r_sk_vld <= 1'b0;
      r_rdy    <= 1'b0;
      r_live   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      r_rdy  <= ~w_sk_nxt;
      if (w_hd_free) begin
        if (SKID && r_sk_vld) begin
          r_hd     <= r_sk;
          r_pend_s <= 1'b1;
          r_pend_m <= r_sk.train;
          r_sk_vld <= w_acc;
          if (w_acc) r_sk <= w_new;
        end else if (w_acc) begin
          r_hd     <= w_new;
          r_pend_s <= 1'b1;
          r_pend_m <= w_new.train;
        end else begin
          r_pend_s <= 1'b0;
          r_pend_m <= 1'b0;
        end
      end else begin
        r_pend_s <= w_s_left;
        r_pend_m <= w_m_left;
        if (SKID && w_acc) begin
          r_sk     <= w_new;
          r_sk_vld <= 1'b1;
        end
      end
    end
  end

  assign bus.oReady_AM_Accum = w_ready;
  assign bus.oValid_BM_State = r_pend_s;
  assign bus.oValid_BM_Mask  = r_pend_m;
  assign bus.oData_BM_State  = r_hd.state;
  assign bus.oData_BM_Mask   = r_hd.mask;

endmodule
